controller_state_machine: RTL and testbench
===========================================

# controller_state_machine

Control unit of the 16-bit CPU. It holds the 7-bit program counter (PC), the 16-bit instruction register (IR) and the fetch/decode/execute state machine. It sits between the external instruction ROM and the datapath, which contains the register file, the ALU and the data memory. It fetches one instruction word at a time and drives the register-file, ALU and data-memory control lines needed to execute it.

## Interface
- No parameters.
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- IMem_Q  input  16  instruction ROM read data for address PC_Out; one-cycle synchronous read.
- PC_Out  output  7  program counter, drives the ROM address.
- IR_Out  output  16  instruction register contents.
- OutState  output  4  current state code.
- NextState  output  4  next state code (combinational).
- D_Addr  output  8  data-memory address.
- D_Wr  output  1  data-memory write enable.
- RF_s  output  1  register-file write-data select: 1 = data memory, 0 = ALU.
- RF_W_en  output  1  register-file write enable.
- RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  output  4 each  register-file A-read, B-read and write addresses.
- ALU_s0  output  3  ALU function: 000 = pass/idle, 001 = add, 010 = subtract.

## Operation
- Instruction format: opcode = IR[15:12].
  - NOOP 0000.
  - STORE 0001: D_Addr = IR[11:4], RF_Ra_Addr = IR[3:0].
  - LOAD 0010: D_Addr = IR[11:4], RF_W_Addr = IR[3:0].
  - ADD 0011 and SUB 0100: RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0].
  - HALT 0101.
  - Opcodes 0110–1111 execute as NOOP.
- State codes: Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
- Transitions:
  - Init→Fetch.
  - Fetch→Decode.
  - Decode→Noop, LoadA, Store, Add, Sub or Halt, by opcode.
  - LoadA→LoadB.
  - Noop, LoadB, Store, Add and Sub→Fetch.
  - Halt→Halt; only reset leaves Halt.
- Outputs are 0 in every state unless listed below:
  - Init: internal PC clear asserted.
  - Fetch: IR load (IR←IMem_Q) and PC increment asserted.
  - LoadA: D_Addr, RF_s=1, RF_W_Addr driven; no write.
  - LoadB: as LoadA, plus RF_W_en=1.
  - Store: D_Addr, RF_Ra_Addr driven; D_Wr=1.
  - Add: Ra, Rb and W addresses driven; ALU_s0=001, RF_s=0, RF_W_en=1.
  - Sub: as Add with ALU_s0=010.
- PC:
  - 7-bit up counter; clear has priority over increment.
  - Wraps 127→0 with no flag.
  - Holds its value when neither clear nor increment is asserted.
- IR: loads only in Fetch, otherwise holds.

## Timing
- Reset (Rst=0), applied immediately and asynchronously:
  - State=Init, PC=0, IR=0.
  - All control outputs 0, OutState=0, NextState=1.
- Reset asserted mid-instruction aborts the instruction immediately, including any pending D_Wr or RF_W_en.
- IR and PC update on the same Fetch edge.
- The ROM read latency is covered by Decode: the new PC is presented during Decode, so IMem_Q is valid for the next Fetch.
- Init lasts one cycle with PC=0, so mem[0] is valid at the first Fetch.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB: 3 cycles (Fetch, Decode, execute).
  - LOAD: 4 cycles, register write in the LoadB cycle.
  - HALT: after Fetch and Decode, stays in Halt with all outputs idle.
- Control outputs are combinational from state and IR, and valid for the whole state cycle.
- Write strobes are single-cycle pulses.

## Configuration
- CTRL_STATE_DEBUG_EN:
  - Defined: OutState and NextState show the state codes as specified.
  - Undefined: both are tied to 0 and the state machine behaviour is unchanged.

## Test plan
- Reset: hold Rst=0 for 60 ns, then release → PC=0, IR=0, OutState=0 while in reset; after release the state sequence is 0,1,2.
- NOOP stream (mem = 0x0000…) → state sequence 1,2,3 repeating; PC increments by 1 per instruction; all strobes stay 0.
- STORE 0x1A53 → in state 6: D_Addr=0xA5, RF_Ra_Addr=3, D_Wr=1 for exactly one cycle.
- LOAD 0x2104 → states 4 then 5 with D_Addr=0x10, RF_s=1, RF_W_Addr=4; RF_W_en=1 only in state 5.
- ADD 0x3123 then SUB 0x4123 → Ra=1, Rb=2, W=3; ALU_s0=001 then 010; RF_W_en=1; RF_s=0.
- HALT 0x5000 at address 5 → state stays 9; PC stays 6; a reset pulse restarts from PC=0. Also run 128 NOOPs → PC wraps 127→0.

Source files
------------

// File: rtl/controller_state_machine_if.sv
// Bus between the CPU control unit, the instruction ROM and the datapath.
//   IMem_Q               ROM read data for address PC_Out (one-cycle synchronous read)
//   PC_Out, IR_Out       program counter and instruction register
//   OutState, NextState  current / next state codes (zero unless CTRL_STATE_DEBUG_EN)
//   D_Addr, D_Wr         data-memory address and write strobe
//   RF_s, RF_W_en        register-file write-data select (1 = memory) and write enable
//   RF_*_Addr            register-file A-read, B-read and write addresses
//   ALU_s0               ALU function: 000 pass, 001 add, 010 subtract
// master = control unit, slave = ROM/datapath side.
interface controller_state_machine_if;
   logic [15:0] IMem_Q;
   logic [6:0]  PC_Out;
   logic [15:0] IR_Out;
   logic [3:0]  OutState;
   logic [3:0]  NextState;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic [3:0]  RF_W_Addr;
   logic [2:0]  ALU_s0;

   modport master (
      input  IMem_Q,
      output PC_Out, IR_Out, OutState, NextState, D_Addr, D_Wr, RF_s, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0
   );

   modport slave (
      output IMem_Q,
      input  PC_Out, IR_Out, OutState, NextState, D_Addr, D_Wr, RF_s, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0
   );
endinterface

// File: rtl/controller_state_machine.sv
// Control unit of the 16-bit CPU: program counter, instruction register and the
// fetch/decode/execute state machine driving register-file, ALU and data-memory controls.
// Ports:
//   Clk  system clock, rising edge
//   Rst  asynchronous active-low reset
//   bus  controller_state_machine_if.master (ROM data in, PC/IR/control outputs)
// Build option: define CTRL_STATE_DEBUG_EN to expose the state codes on OutState and
// NextState; otherwise both read as zero.
module controller_state_machine (
   input logic                        Clk,
   input logic                        Rst,
   controller_state_machine_if.master bus
);

   typedef enum logic [3:0] {
      StInit   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StNoop   = 4'd3,
      StLoadA  = 4'd4,
      StLoadB  = 4'd5,
      StStore  = 4'd6,
      StAdd    = 4'd7,
      StSub    = 4'd8,
      StHalt   = 4'd9
   } state_e;

   state_e      state_q, state_d;
   logic [6:0]  pc_q;
   logic [15:0] ir_q;
   logic        pc_clr, pc_inc, ir_ld;
   logic [3:0]  opcode;

   logic [7:0]  d_addr;
   logic        d_wr, rf_s, rf_w_en;
   logic [3:0]  ra_addr, rb_addr, w_addr;
   logic [2:0]  alu_s0;

   assign opcode = ir_q[15:12];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear wins over increment; 7-bit counter wraps naturally.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pc_q <= 7'd0;
      end else if (pc_clr) begin
         pc_q <= 7'd0;
      end else if (pc_inc) begin
         pc_q <= pc_q + 7'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ir_q <= 16'd0;
      end else if (ir_ld) begin
         ir_q <= bus.IMem_Q;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_clr  = 1'b0;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      d_addr  = 8'd0;
      d_wr    = 1'b0;
      rf_s    = 1'b0;
      rf_w_en = 1'b0;
      ra_addr = 4'd0;
      rb_addr = 4'd0;
      w_addr  = 4'd0;
      alu_s0  = 3'b000;

      unique case (state_q)
         StInit: begin
            pc_clr  = 1'b1;
            state_d = StFetch;
         end
         StFetch: begin
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            // Undefined opcodes 6..15 fall through to Noop.
            case (opcode)
               4'h1:    state_d = StStore;
               4'h2:    state_d = StLoadA;
               4'h3:    state_d = StAdd;
               4'h4:    state_d = StSub;
               4'h5:    state_d = StHalt;
               default: state_d = StNoop;
            endcase
         end
         StNoop: begin
            state_d = StFetch;
         end
         StLoadA: begin
            d_addr  = ir_q[11:4];
            rf_s    = 1'b1;
            w_addr  = ir_q[3:0];
            state_d = StLoadB;
         end
         StLoadB: begin
            d_addr  = ir_q[11:4];
            rf_s    = 1'b1;
            w_addr  = ir_q[3:0];
            rf_w_en = 1'b1;
            state_d = StFetch;
         end
         StStore: begin
            d_addr  = ir_q[11:4];
            ra_addr = ir_q[3:0];
            d_wr    = 1'b1;
            state_d = StFetch;
         end
         StAdd, StSub: begin
            ra_addr = ir_q[11:8];
            rb_addr = ir_q[7:4];
            w_addr  = ir_q[3:0];
            alu_s0  = (state_q == StAdd) ? 3'b001 : 3'b010;
            rf_w_en = 1'b1;
            state_d = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   assign bus.PC_Out     = pc_q;
   assign bus.IR_Out     = ir_q;
   assign bus.D_Addr     = d_addr;
   assign bus.D_Wr       = d_wr;
   assign bus.RF_s       = rf_s;
   assign bus.RF_W_en    = rf_w_en;
   assign bus.RF_Ra_Addr = ra_addr;
   assign bus.RF_Rb_Addr = rb_addr;
   assign bus.RF_W_Addr  = w_addr;
   assign bus.ALU_s0     = alu_s0;

`ifdef CTRL_STATE_DEBUG_EN
   assign bus.OutState  = state_q;
   assign bus.NextState = state_d;
`else
   assign bus.OutState  = 4'd0;
   assign bus.NextState = 4'd0;
`endif

endmodule

// File: tb/tb_controller_state_machine.sv
// Self-checking bench for controller_state_machine: per-cycle expected-output table for a
// small program, plus hand-written reset, halt-restart and PC-wrap sequences.
module tb_controller_state_machine;

`ifdef CTRL_STATE_DEBUG_EN
   localparam bit Dbg = 1'b1;
`else
   localparam bit Dbg = 1'b0;
`endif

   logic clk;
   logic rst;
   logic [15:0] mem [128];
   int errors;
   int checks;

   controller_state_machine_if bus_if ();

   controller_state_machine dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction ROM.
   always @(posedge clk) bus_if.IMem_Q <= mem[bus_if.PC_Out];

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  nst;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [7:0]  da;
      logic        dwr;
      logic        rfs;
      logic        we;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  wa;
      logic [2:0]  alu;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(input logic [3:0] st, input logic [3:0] nst,
                               input logic [6:0] pc, input logic [15:0] ir,
                               input logic [7:0] da, input logic dwr, input logic rfs,
                               input logic we, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] wa, input logic [2:0] alu);
      vec_t v;
      v.st = st; v.nst = nst; v.pc = pc; v.ir = ir; v.da = da; v.dwr = dwr;
      v.rfs = rfs; v.we = we; v.ra = ra; v.rb = rb; v.wa = wa; v.alu = alu;
      return v;
   endfunction

   function automatic logic [3:0] exp_st(input logic [3:0] c);
      return Dbg ? c : 4'd0;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("step%0d", idx);
      chk({t, ".OutState"},  16'(bus_if.OutState),   16'(exp_st(v.st)));
      chk({t, ".NextState"}, 16'(bus_if.NextState),  16'(exp_st(v.nst)));
      chk({t, ".PC"},        16'(bus_if.PC_Out),     16'(v.pc));
      chk({t, ".IR"},        bus_if.IR_Out,          v.ir);
      chk({t, ".D_Addr"},    16'(bus_if.D_Addr),     16'(v.da));
      chk({t, ".D_Wr"},      16'(bus_if.D_Wr),       16'(v.dwr));
      chk({t, ".RF_s"},      16'(bus_if.RF_s),       16'(v.rfs));
      chk({t, ".RF_W_en"},   16'(bus_if.RF_W_en),    16'(v.we));
      chk({t, ".Ra"},        16'(bus_if.RF_Ra_Addr), 16'(v.ra));
      chk({t, ".Rb"},        16'(bus_if.RF_Rb_Addr), 16'(v.rb));
      chk({t, ".W"},         16'(bus_if.RF_W_Addr),  16'(v.wa));
      chk({t, ".ALU_s0"},    16'(bus_if.ALU_s0),     16'(v.alu));
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Assert reset at a falling edge, then release on the next falling edge.
   task automatic reset_pulse();
      rst = 1'b0;
      #1;
      chk("rst.PC",        16'(bus_if.PC_Out),    16'd0);
      chk("rst.IR",        bus_if.IR_Out,         16'd0);
      chk("rst.OutState",  16'(bus_if.OutState),  16'(exp_st(4'd0)));
      chk("rst.NextState", 16'(bus_if.NextState), 16'(exp_st(4'd1)));
      chk("rst.strobes",   16'({bus_if.D_Wr, bus_if.RF_W_en}), 16'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int strobe_seen;
      errors = 0;
      checks = 0;
      rst    = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      mem[0] = 16'h1A53;  // STORE
      mem[1] = 16'h2104;  // LOAD
      mem[2] = 16'h3123;  // ADD
      mem[3] = 16'h4123;  // SUB
      mem[4] = 16'h0000;  // NOOP
      mem[5] = 16'h5000;  // HALT

      //           st nst pc  ir        da    dwr rfs we ra rb wa alu
      tbl[0]  = mk(0, 1, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 2, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(2, 6, 1, 16'h1A53, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(6, 1, 1, 16'h1A53, 8'hA5, 1, 0, 0, 3, 0, 0, 0);
      tbl[4]  = mk(1, 2, 1, 16'h1A53, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(2, 4, 2, 16'h2104, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(4, 5, 2, 16'h2104, 8'h10, 0, 1, 0, 0, 0, 4, 0);
      tbl[7]  = mk(5, 1, 2, 16'h2104, 8'h10, 0, 1, 1, 0, 0, 4, 0);
      tbl[8]  = mk(1, 2, 2, 16'h2104, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(2, 7, 3, 16'h3123, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(7, 1, 3, 16'h3123, 8'h00, 0, 0, 1, 1, 2, 3, 1);
      tbl[11] = mk(1, 2, 3, 16'h3123, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(2, 8, 4, 16'h4123, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(8, 1, 4, 16'h4123, 8'h00, 0, 0, 1, 1, 2, 3, 2);
      tbl[14] = mk(1, 2, 4, 16'h4123, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(2, 3, 5, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(3, 1, 5, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[17] = mk(1, 2, 5, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(2, 9, 6, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(9, 9, 6, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(9, 9, 6, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(9, 9, 6, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 0);

      // Reset held for 60 ns, released on a falling edge.
      #30;
      chk("hold.PC",       16'(bus_if.PC_Out),   16'd0);
      chk("hold.IR",       bus_if.IR_Out,        16'd0);
      chk("hold.OutState", 16'(bus_if.OutState), 16'(exp_st(4'd0)));
      #30;
      rst = 1'b1;
      #1;
      chk_vec(0, tbl[0]);
      for (int s = 1; s < 22; s++) begin
         step(1);
         chk_vec(s, tbl[s]);
      end

      // Reset pulse out of Halt restarts at PC=0.
      step(5);
      chk("halt.hold.PC", 16'(bus_if.PC_Out), 16'd6);
      reset_pulse();
      #1;
      chk_vec(100, tbl[0]);
      step(2);
      chk_vec(102, tbl[2]);

      // Reset during Store kills the pending write immediately.
      step(1);
      chk("store.D_Wr.before", 16'(bus_if.D_Wr), 16'd1);
      #2;
      reset_pulse();
      step(7);
      chk_vec(207, tbl[7]);

      // Reset during LoadB kills the pending register write.
      #2;
      rst = 1'b0;
      #1;
      chk("loadb.abort.RF_W_en", 16'(bus_if.RF_W_en), 16'd0);
      chk("loadb.abort.RF_s",    16'(bus_if.RF_s),    16'd0);
      chk("loadb.abort.IR",      bus_if.IR_Out,       16'd0);

      // 128 NOOPs: PC wraps 127 -> 0. Fetch of instr i at step 1+3i, Decode at 2+3i.
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      strobe_seen = 0;
      for (int s = 1; s <= 386; s++) begin
         step(1);
         if (bus_if.D_Wr || bus_if.RF_W_en || bus_if.RF_s || (bus_if.ALU_s0 != 3'b000))
            strobe_seen++;
         if (s == 380) chk("wrap.PC127", 16'(bus_if.PC_Out), 16'd127);
         if (s == 382) chk("wrap.fetch.st", 16'(bus_if.OutState), 16'(exp_st(4'd1)));
         if (s == 383) begin
            chk("wrap.PC0", 16'(bus_if.PC_Out), 16'd0);
            chk("wrap.decode.st", 16'(bus_if.OutState), 16'(exp_st(4'd2)));
         end
         if (s == 384) chk("wrap.noop.st", 16'(bus_if.OutState), 16'(exp_st(4'd3)));
         if (s == 386) chk("wrap.PC1", 16'(bus_if.PC_Out), 16'd1);
      end
      chk("noop.strobes", 16'(strobe_seen), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
